vector_packer: RTL and testbench



---
 rtl/vector_pkg.sv | 38 +++
 rtl/vector_packer_if.sv | 24 ++
 rtl/vector_bitrev.sv | 16 +
 rtl/vector_packer.sv | 100 ++++++++++
 tb/tb_vector_packer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// Shared constants, types and helpers for the 16-bit to 48-bit vector packer.
package vector_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned SLOTS = 3;
  localparam int unsigned OUT_W = IN_W * SLOTS;
  localparam int unsigned CNT_W = 8;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    EMIT_IDLE,
    EMIT_FULL
  } emit_state_e;

  localparam slot_t            LAST_SLOT     = slot_t'(SLOTS - 1);
  localparam logic [SLOTS-1:0] KEEP_FULL     = 3'b111;
  localparam slot_t            RST_SLOT      = slot_t'(0);
  localparam logic [OUT_W-1:0] RST_DATA      = '0;
  localparam logic [SLOTS-1:0] RST_KEEP      = '0;
  localparam logic [CNT_W-1:0] RST_FRAME_CNT = '0;

  // Ones for slots 0..s, where slot 0 is the MSB bit of the mask.
  function automatic logic [SLOTS-1:0] keep_mask(input slot_t s);
    return ~(KEEP_FULL >> (32'(s) + 32'd1));
  endfunction

  // Expands a keep mask into a per-bit data mask.
  function automatic logic [OUT_W-1:0] data_mask(input logic [SLOTS-1:0] k);
    logic [OUT_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      m[i*IN_W +: IN_W] = {IN_W{k[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/vector_packer_if.sv
// Stream bundle for the packer: 16-bit ingress and 48-bit egress handshakes.
interface vector_packer_if;
  import vector_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [SLOTS-1:0] out_keep;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );

endinterface

// File: rtl/vector_bitrev.sv
// Combinational IN_W-bit reverser; used by vector_packer when VECTOR_BITREV_EN is defined.
module vector_bitrev
  import vector_pkg::*;
(
  input  logic [IN_W-1:0] i_data,
  output logic [IN_W-1:0] o_data_c
);

  always_comb begin
    o_data_c = '0;
    for (int unsigned i = 0; i < IN_W; i++) begin
      o_data_c[i] = i_data[IN_W-1-i];
    end
  end

endmodule

// File: rtl/vector_packer.sv
// Packs three 16-bit words into one 48-bit word, MSB slot first, flushing early on in_last.
// Define VECTOR_BITREV_EN to bit-reverse each word on ingress.
module vector_packer
  import vector_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  vector_packer_if.slave   io_bus,
  output logic [CNT_W-1:0] o_frame_cnt
);

  emit_state_e      r_emit;
  slot_t            r_slot;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_data;
  logic [SLOTS-1:0] r_keep;
  logic [CNT_W-1:0] r_cnt;

  emit_state_e      w_emit_nxt;
  slot_t            w_slot_nxt;
  logic [OUT_W-1:0] w_acc_nxt;
  logic [OUT_W-1:0] w_data_nxt;
  logic [SLOTS-1:0] w_keep_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [IN_W-1:0]  w_word;
  logic [OUT_W-1:0] w_slotted;
  logic [SLOTS-1:0] w_keep_new;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_complete;

`ifdef VECTOR_BITREV_EN
  vector_bitrev u_bitrev (
    .i_data   (io_bus.in_data),
    .o_data_c (w_word)
  );
`else
  assign w_word = io_bus.in_data;
`endif

  assign w_in_ready = (r_emit == EMIT_IDLE) || io_bus.out_ready;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_complete = w_accept && ((r_slot == LAST_SLOT) || io_bus.in_last);
  assign w_slotted  = OUT_W'(w_word) << (IN_W * (SLOTS - 32'd1 - 32'(r_slot)));
  assign w_keep_new = keep_mask(r_slot);

  // Fill (slot/accumulator) and emit (output register) advance independently.
  always_comb begin
    w_emit_nxt = r_emit;
    w_slot_nxt = r_slot;
    w_acc_nxt  = r_acc;
    w_data_nxt = r_data;
    w_keep_nxt = r_keep;
    w_cnt_nxt  = r_cnt;

    if ((r_emit == EMIT_FULL) && io_bus.out_ready) begin
      w_emit_nxt = EMIT_IDLE;
    end

    if (w_complete) begin
      w_data_nxt = (r_acc | w_slotted) & data_mask(w_keep_new);
      w_keep_nxt = w_keep_new;
      w_emit_nxt = EMIT_FULL;
      w_slot_nxt = RST_SLOT;
      w_acc_nxt  = RST_DATA;
      if (io_bus.in_last) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (w_accept) begin
      w_slot_nxt = r_slot + slot_t'(1);
      w_acc_nxt  = r_acc | w_slotted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_emit <= EMIT_IDLE;
      r_slot <= RST_SLOT;
      r_acc  <= RST_DATA;
      r_data <= RST_DATA;
      r_keep <= RST_KEEP;
      r_cnt  <= RST_FRAME_CNT;
    end else begin
      r_emit <= w_emit_nxt;
      r_slot <= w_slot_nxt;
      r_acc  <= w_acc_nxt;
      r_data <= w_data_nxt;
      r_keep <= w_keep_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_emit == EMIT_FULL);
  assign io_bus.out_data  = r_data;
  assign io_bus.out_keep  = r_keep;
  assign o_frame_cnt      = r_cnt;

endmodule

// File: tb/tb_vector_packer.sv
// Directed, table-driven bench for vector_packer (honours VECTOR_BITREV_EN).
module tb_vector_packer;

  logic       clk;
  logic       rst_n;
  logic [7:0] frame_cnt;
  int         n_cmp;
  int         n_err;

  vector_packer_if bus ();

  vector_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_bus      (bus),
    .o_frame_cnt (frame_cnt)
  );

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        ev;
    logic [47:0] ed;
    logic [2:0]  ek;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] rv(input logic [15:0] x);
    logic [15:0] r;
`ifdef VECTOR_BITREV_EN
    for (int i = 0; i < 16; i++) r[i] = x[15-i];
`else
    r = x;
`endif
    return r;
  endfunction

  function automatic logic [47:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c);
    return {rv(a), rv(b), rv(c)};
  endfunction

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l,
                              input logic ev, input logic [47:0] ed,
                              input logic [2:0] ek, input logic [7:0] ec);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.ev = ev; t.ed = ed; t.ek = ek; t.ec = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    step();
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [47:0] ed,
                         input logic [2:0] ek, input logic [7:0] ec);
    chk({nm, " out_valid"}, 48'(bus.out_valid), 48'(ev));
    chk({nm, " out_data"},  bus.out_data, ed);
    chk({nm, " out_keep"},  48'(bus.out_keep), 48'(ek));
    chk({nm, " frame_cnt"}, 48'(frame_cnt), 48'(ec));
  endtask

  initial begin
    logic [15:0] dx;
    logic [47:0] exp_d;
    n_cmp = 0;
    n_err = 0;
    dx    = 16'hxxxx;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state, observed while reset is held.
    step();
    step();
    chk_out("reset", 1'b0, 48'h0, 3'b000, 8'h00);
    chk("reset in_ready", 48'(bus.in_ready), 48'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 48'(bus.in_ready), 48'h1);

    tbl.push_back(mk(1, 16'h3333, 0, 0, 48'h0, 3'b000, 8'd0));
    tbl.push_back(mk(1, 16'heeee, 0, 0, 48'h0, 3'b000, 8'd0));
    tbl.push_back(mk(0, dx,       1, 0, 48'h0, 3'b000, 8'd0));
    tbl.push_back(mk(1, 16'h0001, 0, 1, pk(16'h3333, 16'heeee, 16'h0001), 3'b111, 8'd0));
    tbl.push_back(mk(1, 16'hABCD, 1, 1, pk(16'hABCD, 16'h0, 16'h0), 3'b100, 8'd1));
    tbl.push_back(mk(1, 16'h1111, 0, 0, pk(16'hABCD, 16'h0, 16'h0), 3'b100, 8'd1));
    tbl.push_back(mk(1, 16'h2222, 1, 1, pk(16'h1111, 16'h2222, 16'h0), 3'b110, 8'd2));
    tbl.push_back(mk(1, 16'h5555, 0, 0, pk(16'h1111, 16'h2222, 16'h0), 3'b110, 8'd2));
    tbl.push_back(mk(0, dx,       0, 0, pk(16'h1111, 16'h2222, 16'h0), 3'b110, 8'd2));
    tbl.push_back(mk(1, 16'h6666, 1, 1, pk(16'h5555, 16'h6666, 16'h0), 3'b110, 8'd3));
    tbl.push_back(mk(0, dx,       0, 0, pk(16'h5555, 16'h6666, 16'h0), 3'b110, 8'd3));

    foreach (tbl[i]) begin
      bus.in_valid = tbl[i].v;
      bus.in_data  = tbl[i].d;
      bus.in_last  = tbl[i].l;
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ek, tbl[i].ec);
      chk($sformatf("vec%0d in_ready", i), 48'(bus.in_ready), 48'h1);
    end

    // Back-pressure: output held, in_ready low, then drain+complete with no gap.
    bus.out_ready = 1'b0;
    send(16'h7777, 1'b0);
    chk("bp w1 in_ready", 48'(bus.in_ready), 48'h1);
    send(16'h8888, 1'b0);
    send(16'h9999, 1'b0);
    exp_d = pk(16'h7777, 16'h8888, 16'h9999);
    chk_out("bp full", 1'b1, exp_d, 3'b111, 8'd3);
    chk("bp in_ready", 48'(bus.in_ready), 48'h0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4444;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("bp hold%0d", k), 1'b1, exp_d, 3'b111, 8'd3);
      chk($sformatf("bp hold%0d in_ready", k), 48'(bus.in_ready), 48'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp release in_ready", 48'(bus.in_ready), 48'h1);
    step();
    chk_out("bp b2b", 1'b1, pk(16'h4444, 16'h0, 16'h0), 3'b100, 8'd4);
    bus.in_valid = 1'b0;
    step();
    chk("bp drained", 48'(bus.out_valid), 48'h0);

    // Reset mid-frame discards the partial word.
    send(16'h1234, 1'b0);
    send(16'h5678, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 48'h0, 3'b000, 8'h00);
    chk("midrst in_ready", 48'(bus.in_ready), 48'h1);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0000, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0F0F, 1'b0);
    chk_out("after rst", 1'b1, pk(16'h0000, 16'hFFFF, 16'h0F0F), 3'b111, 8'd0);

    // 256 single-word frames: frame_cnt wraps back to zero.
    for (int i = 0; i < 256; i++) begin
      send(16'(i + 16'h0100), 1'b1);
      chk_out($sformatf("wrap%0d", i), 1'b1, pk(16'(i + 16'h0100), 16'h0, 16'h0),
              3'b100, 8'(i + 1));
    end
    chk("wrap final", 48'(frame_cnt), 48'h0);

    // Bit-order vector with hand-computed result for each build.
    send(16'h8000, 1'b0);
    send(16'h0001, 1'b0);
    send(16'h00FF, 1'b0);
`ifdef VECTOR_BITREV_EN
    chk_out("bitrev", 1'b1, 48'h0001_8000_FF00, 3'b111, 8'd0);
`else
    chk_out("bitrev", 1'b1, 48'h8000_0001_00FF, 3'b111, 8'd0);
`endif
    bus.in_valid = 1'b0;
    step();
    chk("final drain", 48'(bus.out_valid), 48'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
